// File: rtl/bus_timer.sv
// bus_timer: 16-bit down-counting timer in an 8-byte CPU register window.
// Latency: register reads return on DI one cycle after the address; IRQ follows IF&IE by one cycle.
// Backpressure: RDY=0 suppresses writes and read side effects, and DI returns 0 for that cycle.
//
// Ports:
//   clk  - CPU clock, all state changes on its rising edge
//   RST  - asynchronous active-low reset
//   AD   - CPU address; the window is selected when AD[15:3] == BASE[15:3]
//   DO   - CPU write data
//   WE   - CPU write enable (active-high)
//   RDY  - bus ready; qualifies writes and read side effects
//   DI   - registered read data, 0 when not reading so it can be OR-muxed
//   IRQ  - registered interrupt request, IF & IE
//
// Register map: 0 CNT_L, 1 CNT_H (shadow), 2 RLD_L, 3 RLD_H, 4 CTRL {ONESHOT,IE,EN},
//               5 STAT {IF} write-1-clear, 6 PRE, 7 reads 0.
// Optional feature: define TIMER_PRESCALE_EN to add the 8-bit prescaler at offset 6.
module bus_timer #(
   parameter logic [15:0] BASE = 16'hFE00
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] AD,
   input  logic [7:0]  DO,
   input  logic        WE,
   input  logic        RDY,
   output logic [7:0]  DI,
   output logic        IRQ
);

   localparam logic [2:0] OFF_CNT_L = 3'd0;
   localparam logic [2:0] OFF_CNT_H = 3'd1;
   localparam logic [2:0] OFF_RLD_L = 3'd2;
   localparam logic [2:0] OFF_RLD_H = 3'd3;
   localparam logic [2:0] OFF_CTRL  = 3'd4;
   localparam logic [2:0] OFF_STAT  = 3'd5;
   localparam logic [2:0] OFF_PRE   = 3'd6;

   // bus decode
   logic       sel;
   logic [2:0] offset;
   logic       rd_en;
   logic       wr_en;

   // timer state
   logic [15:0] cnt;
   logic [15:0] rld;
   logic [7:0]  hold;
   logic [7:0]  shadow;
   logic        en;
   logic        ie;
   logic        oneshot;
   logic        if_flag;
   logic        en_prev;

   // next-state / datapath
   logic        load;
   logic        tick;
   logic        underflow;
   logic [15:0] cnt_nxt;
   logic        en_nxt;
   logic        if_nxt;
   logic [7:0]  rd_dat;

`ifdef TIMER_PRESCALE_EN
   logic [7:0]  pre;
   logic [7:0]  pcnt;
`endif

   assign sel    = (AD[15:3] == BASE[15:3]);
   assign offset = AD[2:0];
   assign rd_en  = sel & ~WE & RDY;
   assign wr_en  = sel &  WE & RDY;

   // EN rising edge: reload from RLD, and that cycle does not count as a tick
   assign load = en & ~en_prev;

`ifdef TIMER_PRESCALE_EN
   // >= rather than == so lowering PRE below the running count cannot stall the prescaler
   assign tick = en & ~load & (pcnt >= pre);
`else
   assign tick = en & ~load;
`endif

   assign underflow = tick & (cnt == 16'd0);

   always_comb begin
      cnt_nxt = cnt;
      en_nxt  = en;
      if_nxt  = if_flag;

      if (load) begin
         cnt_nxt = rld;
      end else if (tick) begin
         if (cnt != 16'd0) begin
            cnt_nxt = cnt - 16'd1;
         end else if (!oneshot) begin
            cnt_nxt = rld;
         end
      end

      if (wr_en && offset == OFF_CTRL) begin
         en_nxt = DO[0];
      end
      // oneshot expiry wins over a same-edge CTRL write
      if (underflow && oneshot) begin
         en_nxt = 1'b0;
      end

      if (wr_en && offset == OFF_STAT && DO[0]) begin
         if_nxt = 1'b0;
      end
      // a new underflow wins over a same-edge clear
      if (underflow) begin
         if_nxt = 1'b1;
      end
   end

   always_comb begin
      rd_dat = 8'h00;
      case (offset)
         OFF_CNT_L: rd_dat = cnt[7:0];
         OFF_CNT_H: rd_dat = shadow;
         OFF_RLD_L: rd_dat = rld[7:0];
         OFF_RLD_H: rd_dat = rld[15:8];
         OFF_CTRL:  rd_dat = {5'b0, oneshot, ie, en};
         OFF_STAT:  rd_dat = {7'b0, if_flag};
`ifdef TIMER_PRESCALE_EN
         OFF_PRE:   rd_dat = pre;
`endif
         default:   rd_dat = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         cnt     <= 16'd0;
         rld     <= 16'd0;
         hold    <= 8'd0;
         shadow  <= 8'd0;
         en      <= 1'b0;
         ie      <= 1'b0;
         oneshot <= 1'b0;
         if_flag <= 1'b0;
         en_prev <= 1'b0;
         DI      <= 8'd0;
         IRQ     <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         en      <= en_nxt;
         en_prev <= en;
         if_flag <= if_nxt;

         if (wr_en && offset == OFF_CTRL) begin
            ie      <= DO[1];
            oneshot <= DO[2];
         end
         if (wr_en && offset == OFF_RLD_L) begin
            hold <= DO;
         end
         if (wr_en && offset == OFF_RLD_H) begin
            rld <= {DO, hold};
         end
         // latch the high byte with the low byte so a two-byte read is coherent
         if (rd_en && offset == OFF_CNT_L) begin
            shadow <= cnt[15:8];
         end

         DI  <= rd_en ? rd_dat : 8'h00;
         IRQ <= if_flag & ie;
      end
   end

`ifdef TIMER_PRESCALE_EN
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         pre  <= 8'd0;
         pcnt <= 8'd0;
      end else begin
         if (wr_en && offset == OFF_PRE) begin
            pre <= DO;
         end
         if (load || !en) begin
            pcnt <= 8'd0;
         end else if (pcnt >= pre) begin
            pcnt <= 8'd0;
         end else begin
            pcnt <= pcnt + 8'd1;
         end
      end
   end
`endif

endmodule
